// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: fetch FSM states and default address constants.
package mips_pkg;

  localparam int          ADDR_W_DEF   = 32;
  localparam int          INSTR_BYTES  = 4;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    SETTLE = 2'd0,
    FETCH  = 2'd1,
    HOLD   = 2'd2,
    ERR    = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_wait_timer.sv
// Counts FETCH cycles spent waiting for imem_ack; flags expiry on the MAX_WAIT-th waiting cycle.
module fetch_wait_timer #(
  parameter int MAX_WAIT = 15
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic inc,
  output logic expire
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clock) begin
    if (!reset_n || clear) begin
      count <= '0;
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

  // Expire in the waiting cycle that completes MAX_WAIT, so ERR follows exactly MAX_WAIT cycles.
  assign expire = inc && (count == CW'(MAX_WAIT - 1));

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: drives the PC register, fetches over req/ack and holds the word for decode.
// Optional fetch timeout is enabled by defining FETCH_TIMEOUT_EN.
import mips_pkg::*;

module instr_fetch_unit #(
  parameter int              ADDR_W   = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF),
  parameter int              MAX_WAIT = 15
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] new_pc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [ADDR_W-1:0] imem_rdata,
  output logic              ir_valid,
  output logic [ADDR_W-1:0] ir,
  output logic [ADDR_W-1:0] ir_pc,
  input  logic              ir_ready,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              fetch_err
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] new_pc_q, new_pc_d;
  logic [ADDR_W-1:0] ir_q, ir_d;
  logic [ADDR_W-1:0] ir_pc_q, ir_pc_d;
  logic              ir_valid_q, ir_valid_d;
  logic              fetch_err_q, fetch_err_d;
  logic              pend_valid_q, pend_valid_d;
  logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;
  logic              timeout;
  logic              redir_bad;

`ifdef FETCH_TIMEOUT_EN
  fetch_wait_timer #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_timer (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (state_q != FETCH),
    .inc     ((state_q == FETCH) && !imem_ack),
    .expire  (timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  assign redir_bad = redirect_valid && (redirect_pc[1:0] != 2'b00);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q      <= SETTLE;
      new_pc_q     <= RESET_PC;
      ir_q         <= '0;
      ir_pc_q      <= '0;
      ir_valid_q   <= 1'b0;
      fetch_err_q  <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      new_pc_q     <= new_pc_d;
      ir_q         <= ir_d;
      ir_pc_q      <= ir_pc_d;
      ir_valid_q   <= ir_valid_d;
      fetch_err_q  <= fetch_err_d;
      pend_valid_q <= pend_valid_d;
      pend_pc_q    <= pend_pc_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    new_pc_d     = new_pc_q;
    ir_d         = ir_q;
    ir_pc_d      = ir_pc_q;
    ir_valid_d   = ir_valid_q;
    fetch_err_d  = fetch_err_q;
    pend_valid_d = pend_valid_q;
    pend_pc_d    = pend_pc_q;

    case (state_q)
      SETTLE: begin
        pend_valid_d = 1'b0;
        // new_pc is what pc will hold in FETCH, so alignment is checked on it here.
        if (redir_bad) begin
          state_d = ERR;
        end else if (redirect_valid) begin
          new_pc_d = redirect_pc;
        end else if (new_pc_q[1:0] != 2'b00) begin
          state_d = ERR;
        end else begin
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (redir_bad || timeout) begin
          state_d = ERR;
        end else if (imem_ack) begin
          pend_valid_d = 1'b0;
          if (redirect_valid) begin
            new_pc_d = redirect_pc;
            state_d  = SETTLE;
          end else if (pend_valid_q) begin
            new_pc_d = pend_pc_q;
            state_d  = SETTLE;
          end else begin
            ir_d       = imem_rdata;
            ir_pc_d    = pc;
            ir_valid_d = 1'b1;
            new_pc_d   = pc + ADDR_W'(INSTR_BYTES);
            state_d    = HOLD;
          end
        end else if (redirect_valid) begin
          // The request cannot be withdrawn; remember the target until the ack arrives.
          pend_valid_d = 1'b1;
          pend_pc_d    = redirect_pc;
        end
      end
      HOLD: begin
        if (redir_bad) begin
          state_d = ERR;
        end else if (redirect_valid) begin
          new_pc_d   = redirect_pc;
          ir_valid_d = 1'b0;
          state_d    = SETTLE;
        end else if (ir_ready) begin
          ir_valid_d = 1'b0;
          state_d    = SETTLE;
        end
      end
      default: begin
        state_d = ERR;
      end
    endcase

    if (state_d == ERR) begin
      fetch_err_d  = 1'b1;
      ir_valid_d   = 1'b0;
      pend_valid_d = 1'b0;
    end
  end

  assign new_pc    = new_pc_q;
  assign imem_req  = (state_q == FETCH);
  assign imem_addr = pc;
  assign ir_valid  = ir_valid_q;
  assign ir        = ir_q;
  assign ir_pc     = ir_pc_q;
  assign fetch_err = fetch_err_q;

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Consumer side of the program counter. Reads the current PC value, fetches the instruction word from instruction memory over a req/ack handshake, and holds it for decode under valid/ready.
- Drives new_pc back into the PC register, which latches new_pc on every clock edge, to advance, stall or redirect it.
- Sits between the PC register, instruction memory and the decode stage of the single-issue MIPS core.

Parameters:
- ADDR_W, 32, width of the PC, memory address and instruction word.
- RESET_PC, 32'h0000_0000, value driven on new_pc during reset; must be word-aligned.
- MAX_WAIT, 15, cycles allowed from imem_req rising to imem_ack before a timeout (only with FETCH_TIMEOUT_EN).

Ports:
- clock  in  1  single system clock, rising edge.
- reset_n  in  1  reset; one clock; reset is synchronous and active-low.
- pc  in  ADDR_W  current PC register output.
- new_pc  out  ADDR_W  registered next PC, to the PC register input.
- imem_req  out  1  fetch request.
- imem_addr  out  ADDR_W  fetch address; always equals pc.
- imem_ack  in  1  one-cycle acknowledge; imem_rdata is valid in the same cycle.
- imem_rdata  in  ADDR_W  instruction word.
- ir_valid  out  1  instruction available to decode.
- ir  out  ADDR_W  held instruction.
- ir_pc  out  ADDR_W  address ir was fetched from.
- ir_ready  in  1  decode accepts ir.
- redirect_valid  in  1  branch/jump taken; single-cycle pulse.
- redirect_pc  in  ADDR_W  redirect target.
- fetch_err  out  1  sticky error flag.

Behaviour:
- Reset (reset_n=0 at a clock edge):
  - state=SETTLE, new_pc=RESET_PC, imem_req=0, ir_valid=0, ir=0, ir_pc=0, fetch_err=0, pending redirect cleared.
  - Reset must be held at least 2 cycles so the PC register loads RESET_PC.
- The PC register adds one cycle of delay: pc(t+1)=new_pc(t). new_pc is held constant except where stated.
- SETTLE: imem_req=0 for one cycle while pc catches up to new_pc; then go to FETCH.
- FETCH:
  - imem_req=1 with imem_addr=pc; req stays high until ack and is never withdrawn early.
  - On imem_ack with no redirect (current or pending): ir<=imem_rdata, ir_pc<=pc, ir_valid<=1, new_pc<=pc+4 (wraps modulo 2^ADDR_W), go to HOLD.
  - Fetch latency = ack latency + 1 cycle.
- HOLD:
  - ir, ir_pc and ir_valid are held stable while ir_ready=0.
  - On ir_valid&&ir_ready: ir_valid<=0, go to SETTLE. Steady-state throughput is one instruction per 3 cycles with zero-wait memory.
- Redirect (redirect_valid=1), by state:
  - HOLD or SETTLE: new_pc<=redirect_pc, ir_valid<=0 (flush, even if ir_ready is high the same cycle), go to SETTLE.
  - FETCH without ack: latch redirect_pc as pending and keep req high. On the later ack, discard rdata, new_pc<=pending, go to SETTLE.
  - FETCH with ack in the same cycle: discard rdata, new_pc<=redirect_pc, go to SETTLE.
  - A second redirect while one is pending: the newer target wins.
- Alignment:
  - redirect_pc[1:0]!=0, or pc[1:0]!=0 on entry to FETCH, gives state ERR.
  - ERR: fetch_err=1, imem_req=0, ir_valid=0, new_pc held. Only reset exits ERR.
- Reset mid-operation: takes effect at the next edge regardless of state. An outstanding request is dropped, and a late ack after reset is ignored.
- imem_ack outside FETCH is ignored.

Optional Feature:
- Macro: FETCH_TIMEOUT_EN.
- Defined: a wait counter clears on entry to FETCH and increments each FETCH cycle without ack. When it reaches MAX_WAIT the block goes to ERR, fetch_err=1 and imem_req=0.
- Undefined: no counter; FETCH waits indefinitely for ack.

Decomposition:
- Shared package mips_pkg:
  - fetch state enum (SETTLE, FETCH, HOLD, ERR).
  - INSTR_BYTES=4.
  - RESET_PC default constant.
  - ADDR_W default.
- One natural sub-module: fetch_wait_timer (counter plus compare), instantiated only under FETCH_TIMEOUT_EN.
- The FSM and datapath stay in instr_fetch_unit.

Test Plan:
- Reset 3 cycles, then release; PC model loads new_pc, zero-wait memory returning mem[a]=a^32'hA5A5_0000 -> first imem_req at pc=0; ir=32'hA5A5_0000, ir_pc=0; new_pc=4; ir_valid asserts 2 cycles after reset release.
- ir_ready=1 always, memory ack latency 2 -> fetch addresses 0,4,8,12 in order; each ir_valid exactly one cycle; no duplicated or skipped address.
- ir_ready held low 5 cycles in HOLD -> ir and ir_pc stable, imem_req=0, new_pc stays at ir_pc+4 throughout.
- redirect_valid with redirect_pc=32'h0000_0100 two cycles into a 4-cycle-latency fetch of 0x8 -> that data is discarded, ir_valid stays 0, next imem_addr=0x100; same target pulsed in the same cycle as ack -> identical outcome.
- Start from pc=32'hFFFF_FFFC -> new_pc=0 after ack (wrap). redirect_pc=32'h0000_0102 -> fetch_err=1, imem_req=0 until reset.
- FETCH_TIMEOUT_EN, MAX_WAIT=15, memory never acks -> fetch_err=1 after exactly 15 FETCH cycles. Without the macro -> imem_req stays high for 100 cycles and fetch_err stays 0.
